mkgauss_stream: RTL

//  Streaming Falcon keygen Gaussian sampler; emits one full polynomial (N = 2^logn coefficients) per start.

---
 rtl/mkgauss_stream_pkg.sv | 26 ++
 rtl/mkgauss_stream_if.sv | 12 +
 rtl/mkgauss_stream_sampler.sv | 27 ++
 rtl/mkgauss_stream.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mkgauss_stream_pkg.sv
// Shared constants for the Falcon keygen Gaussian sampler: base CDT table,
// FSM state type and the samples-per-coefficient helper.
package falcon_gauss_pkg;

    localparam int GAUSS_TABLE_SIZE = 27;

    localparam logic [63:0] GAUSS_1024_12289 [0:GAUSS_TABLE_SIZE-1] = '{
        64'd1283868770400643928, 64'd6416574995475331444, 64'd4078260278032692663,
        64'd2353523259288686585, 64'd1227179971273316331, 64'd575931623374121527,
        64'd242543240509105209,  64'd91437049221049666,   64'd30799446349977173,
        64'd9255276791179340,    64'd2478152334826140,    64'd590642893610164,
        64'd125206034929641,     64'd23590435911403,      64'd3948334035941,
        64'd586753615614,        64'd77391054539,         64'd9056793210,
        64'd940121950,           64'd86539696,            64'd7062824,
        64'd510971,              64'd32764,               64'd1862,
        64'd94,                  64'd4,                   64'd0
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // g = 2^(10-logn) base samples per output coefficient
    function automatic logic [10:0] g_of_logn(input logic [3:0] logn);
        return 11'd1024 >> logn;
    endfunction

endpackage

// File: rtl/mkgauss_stream_if.sv
// Stream bundle: 128-bit RNG beats in, signed coefficients out (valid/ready both sides).
interface mkgauss_stream_if #(parameter int OUT_W = 16);
    logic                    rng_valid;
    logic [127:0]            rng;
    logic                    rng_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_val;

    modport master (input rng_valid, rng, out_ready, output rng_ready, out_valid, out_val);
    modport slave  (output rng_valid, rng, out_ready, input rng_ready, out_valid, out_val);
endinterface

// File: rtl/mkgauss_stream_sampler.sv
// Combinational base sampler: one RNG beat -> one signed sample in [-26, 26].
module gauss_base_sampler
    import falcon_gauss_pkg::*;
(
    input  logic [127:0]      rng_i,
    output logic signed [5:0] s_o
);
    logic [63:0] r1, r2;
    logic        zero;
    logic [5:0]  mag;
    logic        unused_r2_msb;

    // bit 63 of each word is not part of the 63-bit comparisons (r1[63] is the sign)
    assign r1            = {1'b0, rng_i[62:0]};
    assign r2            = {1'b0, rng_i[126:64]};
    assign unused_r2_msb = rng_i[127];
    assign zero          = r1 < GAUSS_1024_12289[0];

    always_comb begin
        mag = 6'd1;
        for (int k = 1; k < GAUSS_TABLE_SIZE; k++)
            if (r2 < GAUSS_1024_12289[k]) mag = mag + 6'd1;
        if (zero)           s_o = '0;
        else if (rng_i[63]) s_o = -$signed(mag);
        else                s_o = $signed(mag);
    end
endmodule

// File: rtl/mkgauss_stream.sv
// Streaming Falcon keygen Gaussian sampler: FSM, accumulator and 2-entry output FIFO.
// Optional MKGAUSS_SQNORM_EN adds a saturating squared-norm output of popped coefficients.
module mkgauss_stream
    import falcon_gauss_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int LOGN_MIN = 1,
    parameter int LOGN_MAX = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       logn,
    mkgauss_stream_if.master strm,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef MKGAUSS_SQNORM_EN
    ,
    output logic [31:0]      sqnorm
`endif
);
    state_t                  state_q;
    logic [10:0]             g_q, n_q, sub_cnt_q, coef_cnt_q;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] fifo_q [2];
    logic                    rd_q, wr_q;
    logic [1:0]              cnt_q;
    logic                    done_q, err_q;

    logic signed [5:0]       samp;
    logic signed [OUT_W-1:0] sum;
    logic                    accept, pop, push, last_coef, logn_ok, start_ok;

    gauss_base_sampler u_base (.rng_i(strm.rng), .s_o(samp));

    assign logn_ok        = (int'(logn) >= LOGN_MIN) && (int'(logn) <= LOGN_MAX);
    assign start_ok       = start && !abort && (state_q == IDLE) && logn_ok;
    assign strm.rng_ready = (state_q == RUN) && (cnt_q < 2'd2);
    assign strm.out_valid = cnt_q != 2'd0;
    assign strm.out_val   = fifo_q[rd_q];
    assign accept         = strm.rng_valid && strm.rng_ready;
    assign pop            = strm.out_valid && strm.out_ready;
    assign sum            = acc_q + {{(OUT_W-6){samp[5]}}, samp};
    assign push           = accept && (sub_cnt_q == g_q - 11'd1);
    assign last_coef      = coef_cnt_q == n_q - 11'd1;
    assign busy           = state_q != IDLE;
    assign done           = done_q;
    assign err            = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= '0;
            n_q        <= '0;
            sub_cnt_q  <= '0;
            coef_cnt_q <= '0;
            acc_q      <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // abort beats any concurrent accept, pop or start
                state_q    <= IDLE;
                sub_cnt_q  <= '0;
                coef_cnt_q <= '0;
                acc_q      <= '0;
                rd_q       <= 1'b0;
                wr_q       <= 1'b0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            state_q    <= RUN;
                            g_q        <= g_of_logn(logn);
                            n_q        <= 11'd1 << logn;
                            sub_cnt_q  <= '0;
                            coef_cnt_q <= '0;
                            acc_q      <= '0;
                            err_q      <= 1'b0;
                        end else if (start) begin
                            err_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (push) begin
                            acc_q      <= '0;
                            sub_cnt_q  <= '0;
                            coef_cnt_q <= coef_cnt_q + 11'd1;
                            if (last_coef) state_q <= DRAIN;
                        end else if (accept) begin
                            acc_q     <= sum;
                            sub_cnt_q <= sub_cnt_q + 11'd1;
                        end
                    end
                    DRAIN: begin
                        if (cnt_q == 2'd0) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                if (push) begin
                    fifo_q[wr_q] <= sum;
                    wr_q         <= ~wr_q;
                end
                if (pop) rd_q <= ~rd_q;
                cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef MKGAUSS_SQNORM_EN
    logic signed [2*OUT_W-1:0] val_x;
    logic [2*OUT_W-1:0]        sq;
    logic [32:0]               sq_sum;
    logic [31:0]               sq_q;

    assign val_x  = {{OUT_W{strm.out_val[OUT_W-1]}}, strm.out_val};
    assign sq     = $unsigned(val_x * val_x);
    assign sq_sum = {1'b0, sq_q} + 33'(sq);
    assign sqnorm = sq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sq_q <= '0;
        else if (start_ok) sq_q <= '0;
        else if (pop)      sq_q <= sq_sum[32] ? 32'hFFFF_FFFF : sq_sum[31:0];
    end
`endif
endmodule
